sim_master_stub: RTL and testbench
==================================

Name: sim_master_stub

Overview:
- Behavioural-but-synthesizable responder for the host-side master handshake: it plays the role of the wishbone master core behind a host interface.
- Consumes input-handler strobes (command/address/data/count) and returns output-handler responses (status/address/data/count) through the ready/enable handshake.
- Backs WRITE and READ with an internal word memory, so host interfaces can be exercised in simulation without the full bus fabric.

Parameters:
- ADDR_WIDTH, 8, log2 of internal memory depth in 32-bit words; addresses wrap modulo 2**ADDR_WIDTH.
- PING_DATA, 32'h0000_0000, data word returned in PING and unknown-command responses.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- o_master_ready  out  1  high when a new command or next write word may be strobed.
- i_ih_reset  in  1  abort in-flight transaction; memory contents preserved.
- i_ih_ready  in  1  single-cycle strobe: command or write word valid.
- i_in_command  in  32  [3:0] opcode; [31:4] ignored.
- i_in_address  in  32  start word address; low ADDR_WIDTH bits used.
- i_in_data  in  32  write data word.
- i_in_data_count  in  28  word count N.
- i_oh_ready  in  1  host can accept a response word.
- o_oh_en  out  1  single-cycle response strobe.
- o_out_status  out  32  ~command of the transaction.
- o_out_address  out  32  word address of this response.
- o_out_data  out  32  response data.
- o_out_data_count  out  28  words remaining after this response.

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, o_master_ready=0, o_oh_en=0, all o_out_* = 0, internal counters 0. Memory is not cleared. o_master_ready rises on the first edge after rst deasserts.
- Opcodes: PING=0, WRITE=1, READ=2, RESET=3, others unknown. N=0 is treated as N=1.
- Accept: a strobe is taken only on an edge where i_ih_ready=1 and o_master_ready=1. A strobe while not ready is ignored.
- IDLE, WRITE accepted: mem[addr] <= in_data; latch cmd, start address, remaining = N-1.
  - If remaining = 0, go to RESP. Otherwise go to WR_DATA with o_master_ready=1.
- WR_DATA: each accepted strobe writes i_in_data to the next address (wrapping); the command/address fields are ignored. Decrement remaining; at 0, go to RESP.
- RESP: one response with status=~cmd, address=start, and a data field chosen by opcode:
  - WRITE: last written word, data_count=0.
  - PING, RESET, unknown: data=PING_DATA, address=0, data_count=0.
  - RESET additionally aborts nothing else and behaves as a ping.
- READ from IDLE: go to RD_DATA with N responses. Response k carries address=start+k (wrapped), data=mem[start+k], data_count=N-1-k.
- Response handshake: o_oh_en is a 1-cycle pulse, issued only on an edge where i_oh_ready=1. o_out_* are valid in that same cycle and hold their value until the next pulse.
- If i_oh_ready stays low the response is pending indefinitely. Back-to-back READ words are allowed on consecutive cycles while i_oh_ready stays high.
- Memory read is synchronous, 1-cycle latency: first READ pulse no earlier than 2 cycles after acceptance. Prefetch the next word so throughput is 1 word/cycle.
- Completion: after the final response pulse, return to IDLE; o_master_ready=1 on the following cycle.
- o_master_ready is 0 in RESP and RD_DATA.
- i_ih_reset=1 (any state): next edge → IDLE, o_oh_en=0, pending response dropped, o_master_ready=1. It takes priority over a simultaneous i_ih_ready.
- rst mid-transaction: same as reset above; partially written words remain in memory.
- Address arithmetic is modulo 2**ADDR_WIDTH; o_out_address reports the wrapped address zero-extended.

Decomposition:
- Shared package holds opcode constants (CMD_PING, CMD_WRITE, CMD_READ, CMD_RESET), the state encoding, and the status = ~command rule.
- One natural sub-module: sim_stub_ram (single-port, 32-bit, synchronous read, depth 2**ADDR_WIDTH).

Test Plan:
- rst for 3 cycles, then release → o_master_ready=1 one edge later; o_oh_en=0 and all o_out_*=0 during reset.
- PING (cmd=0) with i_oh_ready=1 → one o_oh_en pulse, status=FFFF_FFFF, data=0, data_count=0.
- WRITE addr=0x10, N=3, data 0xA,0xB,0xC → single response: status=FFFF_FFFE, address=0x10, data=0xC, count=0. Then READ addr=0x10 N=3 → data A,B,C on 3 consecutive pulses, counts 2,1,0, addresses 0x10–0x12.
- Wrap: WRITE addr=0xFF, N=2 with ADDR_WIDTH=8 → words land at 0xFF and 0x00. READ addr=0xFF N=2 → addresses 0xFF, 0x00.
- Backpressure: READ N=4 with i_oh_ready toggling 1,0,0,1,… → exactly 4 pulses, each only when i_oh_ready=1, data in order, no word dropped or repeated.
- Abort: READ N=8, assert i_ih_reset after 2nd pulse → no further pulses, o_master_ready=1 next edge. A following PING is answered normally.

Source files
------------

// File: rtl/sim_master_stub_pkg.sv
// Shared definitions for the simulation master stub.
//   - opcode constants carried in command[3:0]
//   - FSM state encoding
//   - status_of():          response status word derived from the command
//   - words_after_first():  remaining-word count after the first word (N=0 acts as N=1)
package sim_master_stub_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 28;

   localparam logic [3:0] CMD_PING  = 4'd0;
   localparam logic [3:0] CMD_WRITE = 4'd1;
   localparam logic [3:0] CMD_READ  = 4'd2;
   localparam logic [3:0] CMD_RESET = 4'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR_DATA = 2'd1,
      ST_RESP    = 2'd2,
      ST_RD_DATA = 2'd3
   } state_t;

   function automatic logic [DATA_W-1:0] status_of(input logic [DATA_W-1:0] cmd);
      return ~cmd;
   endfunction

   function automatic logic [CNT_W-1:0] words_after_first(input logic [CNT_W-1:0] n);
      return (n == '0) ? '0 : n - CNT_W'(1);
   endfunction

endpackage

// File: rtl/sim_master_stub_if.sv
// Host-side master handshake bundle.
//   master modport: the stub (drives o_* responses and o_master_ready)
//   slave  modport: the host interface under test (drives i_* strobes)
interface sim_master_stub_if;
   import sim_master_stub_pkg::*;

   logic              o_master_ready;
   logic              i_ih_reset;
   logic              i_ih_ready;
   logic [DATA_W-1:0] i_in_command;
   logic [DATA_W-1:0] i_in_address;
   logic [DATA_W-1:0] i_in_data;
   logic [CNT_W-1:0]  i_in_data_count;
   logic              i_oh_ready;
   logic              o_oh_en;
   logic [DATA_W-1:0] o_out_status;
   logic [DATA_W-1:0] o_out_address;
   logic [DATA_W-1:0] o_out_data;
   logic [CNT_W-1:0]  o_out_data_count;

   modport master (
      output o_master_ready, o_oh_en, o_out_status, o_out_address, o_out_data, o_out_data_count,
      input  i_ih_reset, i_ih_ready, i_in_command, i_in_address, i_in_data, i_in_data_count,
             i_oh_ready
   );

   modport slave (
      input  o_master_ready, o_oh_en, o_out_status, o_out_address, o_out_data, o_out_data_count,
      output i_ih_reset, i_ih_ready, i_in_command, i_in_address, i_in_data, i_in_data_count,
             i_oh_ready
   );

endinterface

// File: rtl/sim_stub_ram.sv
// Single-port word memory backing the stub, synchronous read (1-cycle latency).
// A read on a write cycle returns the old contents. Contents are never cleared.
//   clk    system clock
//   we     write enable
//   addr   word address
//   wdata  write word
//   rdata  word at the address sampled on the previous edge
module sim_stub_ram
   import sim_master_stub_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/sim_master_stub.sv
// Synthesizable stand-in for the wishbone master core behind a host interface.
// Takes command/write strobes, answers with status/address/data/count responses,
// and backs WRITE/READ with an internal word memory.
//   clk, rst   system clock, synchronous active-high reset
//   bus        handshake bundle (master modport)
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for a command strobe
// ST_WR_DATA | collecting the remaining write words of a burst
// ST_RESP    | single response pending (WRITE, PING, RESET, unknown)
// ST_RD_DATA | streaming READ responses from memory
module sim_master_stub
   import sim_master_stub_pkg::*;
#(
   parameter int                ADDR_WIDTH = 8,
   parameter logic [DATA_W-1:0] PING_DATA  = 32'h0000_0000
) (
   input logic                clk,
   input logic                rst,
   sim_master_stub_if.master  bus
);

   state_t                state_q, state_d;
   logic                  ready_q, ready_d;
   logic                  oh_en_q, oh_en_d;
   logic [DATA_W-1:0]     status_q, status_d;
   logic [DATA_W-1:0]     out_addr_q, out_addr_d;
   logic [DATA_W-1:0]     out_data_q, out_data_d;
   logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
   logic [DATA_W-1:0]     cmd_q, cmd_d;
   logic [ADDR_WIDTH-1:0] start_q, start_d;
   logic [ADDR_WIDTH-1:0] cur_q, cur_d;
   logic [CNT_W-1:0]      remain_q, remain_d;
   logic [DATA_W-1:0]     last_q, last_d;
   logic                  rd_valid_q, rd_valid_d;

   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_W-1:0]     ram_rdata;

   logic                  accept;
   logic                  resp_ok;
   logic                  fire;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic [CNT_W-1:0]      first_remain;
   logic                  unused_addr_hi;

   assign in_addr        = bus.i_in_address[ADDR_WIDTH-1:0];
   assign unused_addr_hi = ^bus.i_in_address[DATA_W-1:ADDR_WIDTH];
   assign first_remain   = words_after_first(bus.i_in_data_count);

   // Abort outranks both a new strobe and a response that would otherwise fire.
   assign accept  = bus.i_ih_ready && ready_q && !bus.i_ih_reset;
   assign resp_ok = bus.i_oh_ready && !bus.i_ih_reset;

   sim_stub_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (bus.i_in_data),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ready_q    <= 1'b0;
         oh_en_q    <= 1'b0;
         status_q   <= '0;
         out_addr_q <= '0;
         out_data_q <= '0;
         out_cnt_q  <= '0;
         cmd_q      <= '0;
         start_q    <= '0;
         cur_q      <= '0;
         remain_q   <= '0;
         last_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         oh_en_q    <= oh_en_d;
         status_q   <= status_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
         out_cnt_q  <= out_cnt_d;
         cmd_q      <= cmd_d;
         start_q    <= start_d;
         cur_q      <= cur_d;
         remain_q   <= remain_d;
         last_q     <= last_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      status_d   = status_q;
      out_addr_d = out_addr_q;
      out_data_d = out_data_q;
      out_cnt_d  = out_cnt_q;
      cmd_d      = cmd_q;
      start_d    = start_q;
      cur_d      = cur_q;
      remain_d   = remain_q;
      last_d     = last_q;
      rd_valid_d = rd_valid_q;
      ram_we     = 1'b0;
      ram_addr   = cur_q;
      fire       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            ram_addr = in_addr;
            if (accept) begin
               cmd_d      = bus.i_in_command;
               start_d    = in_addr;
               cur_d      = in_addr + ADDR_WIDTH'(1);
               remain_d   = first_remain;
               rd_valid_d = 1'b0;
               case (bus.i_in_command[3:0])
                  CMD_WRITE: begin
                     ram_we  = 1'b1;
                     last_d  = bus.i_in_data;
                     state_d = (first_remain == '0) ? ST_RESP : ST_WR_DATA;
                  end
                  CMD_READ: begin
                     cur_d   = in_addr;
                     state_d = ST_RD_DATA;
                  end
                  default: state_d = ST_RESP;
               endcase
            end
         end

         ST_WR_DATA: begin
            if (accept) begin
               ram_we   = 1'b1;
               last_d   = bus.i_in_data;
               cur_d    = cur_q + ADDR_WIDTH'(1);
               remain_d = remain_q - CNT_W'(1);
               if (remain_q == CNT_W'(1)) state_d = ST_RESP;
            end
         end

         ST_RESP: begin
            if (resp_ok) begin
               fire      = 1'b1;
               status_d  = status_of(cmd_q);
               out_cnt_d = '0;
               if (cmd_q[3:0] == CMD_WRITE) begin
                  out_addr_d = DATA_W'(start_q);
                  out_data_d = last_q;
               end else begin
                  out_addr_d = '0;
                  out_data_d = PING_DATA;
               end
               state_d = ST_IDLE;
            end
         end

         ST_RD_DATA: begin
            // ram_rdata holds mem[cur_q] once rd_valid_q is set; while stalled the
            // same address is re-read so the word stays put, and on a pulse the
            // next address is fetched so words can go out every cycle.
            if (!rd_valid_q) begin
               rd_valid_d = 1'b1;
            end else if (resp_ok) begin
               fire       = 1'b1;
               status_d   = status_of(cmd_q);
               out_addr_d = DATA_W'(cur_q);
               out_data_d = ram_rdata;
               out_cnt_d  = remain_q;
               if (remain_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  cur_d    = cur_q + ADDR_WIDTH'(1);
                  remain_d = remain_q - CNT_W'(1);
                  ram_addr = cur_q + ADDR_WIDTH'(1);
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase

      if (bus.i_ih_reset) begin
         state_d    = ST_IDLE;
         rd_valid_d = 1'b0;
      end

      oh_en_d = fire;
      // Ready comes back the cycle after the final pulse, not with it.
      ready_d = ((state_d == ST_IDLE) || (state_d == ST_WR_DATA)) && !fire;
   end

   assign bus.o_master_ready   = ready_q;
   assign bus.o_oh_en          = oh_en_q;
   assign bus.o_out_status     = status_q;
   assign bus.o_out_address    = out_addr_q;
   assign bus.o_out_data       = out_data_q;
   assign bus.o_out_data_count = out_cnt_q;

endmodule

// File: tb/tb_sim_master_stub.sv
module tb_sim_master_stub;
   import sim_master_stub_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sim_master_stub_if bus();

   sim_master_stub #(.ADDR_WIDTH(8), .PING_DATA(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] st;
      logic [31:0] ad;
      logic [31:0] da;
      logic [27:0] cnt;
      int          cyc;
   } resp_t;

   typedef struct {
      logic [31:0] cmd;
      logic [31:0] addr;
      logic [31:0] data;
      logic [27:0] cnt;
      logic [31:0] e_st;
      logic [31:0] e_ad;
      logic [31:0] e_da;
      logic [27:0] e_cnt;
   } vec_t;

   resp_t rq[$];
   int    cyc       = 0;
   int    bad_pulse = 0;
   int    acc_cyc   = 0;
   int    n_checks  = 0;
   int    n_pass    = 0;

   // Responses are captured 1 time unit after the edge; the main thread acts 2 after.
   always begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus.o_oh_en === 1'b1) begin
         rq.push_back('{bus.o_out_status, bus.o_out_address, bus.o_out_data,
                        bus.o_out_data_count, cyc});
         if (bus.i_oh_ready !== 1'b1) bad_pulse++;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic wait_resp(input string name, input int n, input int budget);
      for (int i = 0; i < budget && rq.size() < n; i++) step();
      if (rq.size() < n) begin
         n_checks++;
         $display("FAIL %s: timeout, got %0d responses expected %0d", name, rq.size(), n);
      end
   endtask

   task automatic strobe(input logic [31:0] cmd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [27:0] cnt);
      for (int i = 0; i < 50 && bus.o_master_ready !== 1'b1; i++) step();
      chk("ready_before_strobe", {31'd0, bus.o_master_ready}, 32'd1);
      bus.i_in_command    = cmd;
      bus.i_in_address    = addr;
      bus.i_in_data       = data;
      bus.i_in_data_count = cnt;
      bus.i_ih_ready      = 1'b1;
      step();
      acc_cyc        = cyc;
      bus.i_ih_ready = 1'b0;
   endtask

   task automatic chk_resp(input string name, input int idx, input logic [31:0] st,
                           input logic [31:0] ad, input logic [31:0] da, input logic [27:0] cnt);
      if (idx < rq.size()) begin
         chk({name, "_status"}, rq[idx].st, st);
         chk({name, "_addr"},   rq[idx].ad, ad);
         chk({name, "_data"},   rq[idx].da, da);
         chk({name, "_count"},  {4'd0, rq[idx].cnt}, {4'd0, cnt});
      end else begin
         n_checks++;
         $display("FAIL %s: response %0d missing, got %0d responses", name, idx, rq.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam int NV = 7;
   vec_t vecs[NV];
   logic pat[4];

   initial begin
      vecs[0] = '{32'h0000_0000, 32'h0000_0055, 32'h0000_0099, 28'd5,
                  32'hFFFF_FFFF, 32'h0, 32'h0, 28'd0};
      vecs[1] = '{32'h0000_0003, 32'h0000_0012, 32'h0000_0077, 28'd1,
                  32'hFFFF_FFFC, 32'h0, 32'h0, 28'd0};
      vecs[2] = '{32'hABC0_0007, 32'h0000_0033, 32'h0000_0011, 28'd2,
                  32'h543F_FFF8, 32'h0, 32'h0, 28'd0};
      vecs[3] = '{32'h0000_0001, 32'h0001_0021, 32'hDEAD_BEEF, 28'd0,
                  32'hFFFF_FFFE, 32'h21, 32'hDEAD_BEEF, 28'd0};
      vecs[4] = '{32'h0000_0002, 32'h0000_0021, 32'h0, 28'd1,
                  32'hFFFF_FFFD, 32'h21, 32'hDEAD_BEEF, 28'd0};
      vecs[5] = '{32'hF000_0001, 32'h0000_0022, 32'h5A5A_0001, 28'd1,
                  32'h0FFF_FFFE, 32'h22, 32'h5A5A_0001, 28'd0};
      vecs[6] = '{32'h0000_0002, 32'h0000_0122, 32'h0, 28'd0,
                  32'hFFFF_FFFD, 32'h22, 32'h5A5A_0001, 28'd0};
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};

      rst                 = 1'b1;
      bus.i_ih_reset      = 1'b0;
      bus.i_ih_ready      = 1'b0;
      bus.i_in_command    = '0;
      bus.i_in_address    = '0;
      bus.i_in_data       = '0;
      bus.i_in_data_count = '0;
      bus.i_oh_ready      = 1'b1;

      // Reset
      repeat (3) step();
      chk("rst_ready",  {31'd0, bus.o_master_ready}, 32'd0);
      chk("rst_oh_en",  {31'd0, bus.o_oh_en}, 32'd0);
      chk("rst_status", bus.o_out_status, 32'd0);
      chk("rst_addr",   bus.o_out_address, 32'd0);
      chk("rst_data",   bus.o_out_data, 32'd0);
      chk("rst_count",  {4'd0, bus.o_out_data_count}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rel_ready_before_edge", {31'd0, bus.o_master_ready}, 32'd0);
      step();
      chk("rel_ready_after_edge", {31'd0, bus.o_master_ready}, 32'd1);

      // Single-response vectors
      for (int v = 0; v < NV; v++) begin
         rq.delete();
         strobe(vecs[v].cmd, vecs[v].addr, vecs[v].data, vecs[v].cnt);
         wait_resp($sformatf("vec%0d_wait", v), 1, 20);
         repeat (4) step();
         chk($sformatf("vec%0d_npulses", v), rq.size(), 32'd1);
         chk_resp($sformatf("vec%0d", v), 0, vecs[v].e_st, vecs[v].e_ad, vecs[v].e_da, vecs[v].e_cnt);
      end

      // WRITE burst then READ burst
      rq.delete();
      strobe(32'h1, 32'h10, 32'hA, 28'd3);
      strobe(32'h2, 32'h77, 32'hB, 28'd9);
      strobe(32'h0, 32'h55, 32'hC, 28'd1);
      wait_resp("wr3_wait", 1, 20);
      repeat (4) step();
      chk("wr3_npulses", rq.size(), 32'd1);
      chk_resp("wr3", 0, 32'hFFFF_FFFE, 32'h10, 32'hC, 28'd0);

      rq.delete();
      strobe(32'h2, 32'h10, 32'h0, 28'd3);
      wait_resp("rd3_wait", 3, 20);
      repeat (4) step();
      chk("rd3_npulses", rq.size(), 32'd3);
      chk_resp("rd3_w0", 0, 32'hFFFF_FFFD, 32'h10, 32'hA, 28'd2);
      chk_resp("rd3_w1", 1, 32'hFFFF_FFFD, 32'h11, 32'hB, 28'd1);
      chk_resp("rd3_w2", 2, 32'hFFFF_FFFD, 32'h12, 32'hC, 28'd0);
      if (rq.size() == 3) begin
         chk("rd3_latency_ge2", {31'd0, (rq[0].cyc - acc_cyc) >= 2}, 32'd1);
         chk("rd3_b2b_01", rq[1].cyc - rq[0].cyc, 32'd1);
         chk("rd3_b2b_12", rq[2].cyc - rq[1].cyc, 32'd1);
      end

      // Address wrap
      rq.delete();
      strobe(32'h1, 32'hFF, 32'h111, 28'd2);
      strobe(32'h1, 32'h0, 32'h222, 28'd0);
      wait_resp("wrap_wr_wait", 1, 20);
      repeat (3) step();
      chk_resp("wrap_wr", 0, 32'hFFFF_FFFE, 32'hFF, 32'h222, 28'd0);
      rq.delete();
      strobe(32'h2, 32'hFF, 32'h0, 28'd2);
      wait_resp("wrap_rd_wait", 2, 20);
      repeat (3) step();
      chk("wrap_rd_npulses", rq.size(), 32'd2);
      chk_resp("wrap_rd_w0", 0, 32'hFFFF_FFFD, 32'hFF, 32'h111, 28'd1);
      chk_resp("wrap_rd_w1", 1, 32'hFFFF_FFFD, 32'h00, 32'h222, 28'd0);

      // Backpressure, with an ignored strobe while not ready
      strobe(32'h1, 32'h30, 32'h30, 28'd4);
      for (int k = 1; k < 4; k++) strobe(32'h1, 32'h0, 32'h30 + k, 28'd0);
      wait_resp("bp_wr_wait", 1, 20);
      repeat (3) step();
      rq.delete();
      bad_pulse = 0;
      strobe(32'h2, 32'h30, 32'h0, 28'd4);
      for (int i = 0; i < 40 && rq.size() < 4; i++) begin
         bus.i_oh_ready   = pat[i % 4];
         bus.i_ih_ready   = (i == 1);
         bus.i_in_command = 32'h0;
         step();
      end
      bus.i_ih_ready = 1'b0;
      bus.i_oh_ready = 1'b1;
      repeat (8) step();
      chk("bp_npulses", rq.size(), 32'd4);
      chk("bp_pulse_only_when_ready", bad_pulse, 32'd0);
      for (int k = 0; k < 4; k++)
         chk_resp($sformatf("bp_w%0d", k), k, 32'hFFFF_FFFD, 32'h30 + k, 32'h30 + k, 28'(3 - k));

      // Abort after second READ pulse
      rq.delete();
      strobe(32'h2, 32'h10, 32'h0, 28'd8);
      wait_resp("abort_wait", 2, 30);
      bus.i_ih_reset = 1'b1;
      step();
      bus.i_ih_reset = 1'b0;
      chk("abort_ready", {31'd0, bus.o_master_ready}, 32'd1);
      chk("abort_oh_en", {31'd0, bus.o_oh_en}, 32'd0);
      repeat (10) step();
      chk("abort_npulses", rq.size(), 32'd2);

      // Abort beats a simultaneous strobe in IDLE
      bus.i_ih_reset   = 1'b1;
      bus.i_ih_ready   = 1'b1;
      bus.i_in_command = 32'h0;
      step();
      bus.i_ih_reset = 1'b0;
      bus.i_ih_ready = 1'b0;
      repeat (6) step();
      chk("abort_prio_npulses", rq.size(), 32'd2);

      rq.delete();
      strobe(32'h0, 32'h0, 32'h0, 28'd0);
      wait_resp("post_abort_ping_wait", 1, 20);
      repeat (3) step();
      chk("post_abort_ping_npulses", rq.size(), 32'd1);
      chk_resp("post_abort_ping", 0, 32'hFFFF_FFFF, 32'h0, 32'h0, 28'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
